// File: rtl/palette_lut.sv
// Programmable colour-index to RGB palette with a per-entry horizontal blue gradient
// and a frame-synchronous global fade engine; two-stage pipeline, one pixel per cycle.
module palette_lut #(
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned CH_W       = 8,
    parameter int unsigned LVL_W      = 4,
    parameter int unsigned FADE_STEP  = 1,
    parameter int unsigned GRAD_SHIFT = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_valid_in,
    input  logic [IDX_W-1:0]  idx_in,
    input  logic [9:0]        DrawX,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [3*CH_W:0]   wr_data,
    input  logic              frame_start,
    input  logic [1:0]        fade_cmd,
    output logic [CH_W-1:0]   R,
    output logic [CH_W-1:0]   G,
    output logic [CH_W-1:0]   B,
    output logic              pix_valid_out,
    output logic              fade_busy,
    output logic              fade_done
);

    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned GW    = 10 - GRAD_SHIFT;
    localparam int unsigned DW    = (CH_W > GW) ? CH_W : GW;
    localparam int unsigned PW    = CH_W + LVL_W + 1;

    localparam logic [LVL_W:0] LVL_MAX  = {1'b1, {LVL_W{1'b0}}};
    localparam logic [LVL_W:0] LVL_STEP = (LVL_W + 1)'(FADE_STEP);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StFadeOut = 2'd1;
    localparam logic [1:0] StDark    = 2'd2;
    localparam logic [1:0] StFadeIn  = 2'd3;

    localparam logic [1:0] CmdOut  = 2'b01;
    localparam logic [1:0] CmdIn   = 2'b10;
    localparam logic [1:0] CmdSnap = 2'b11;

    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                              input logic [LVL_W:0]  lvl);
        logic [PW-1:0] p;
        p = PW'(c) * PW'(lvl);
        return CH_W'(p >> LVL_W);
    endfunction

    // Palette storage: deliberately not reset, contents survive Reset
    logic [3*CH_W:0] r_mem [DEPTH];
    logic [3*CH_W:0] r_rd_data;

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[idx_in];
    end

    logic          r_v1;
    logic [GW-1:0] r_x1;
    logic          w_unused_drawx_lsb;

    assign w_unused_drawx_lsb = ^DrawX[GRAD_SHIFT-1:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_v1 <= 1'b0;
            r_x1 <= '0;
        end else begin
            r_v1 <= pix_valid_in;
            r_x1 <= DrawX[9:GRAD_SHIFT];
        end
    end

    // Fade engine
    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [LVL_W:0] r_level;
    logic [LVL_W:0] w_level_nxt;
    logic           r_done;
    logic           w_done_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_done_nxt  = 1'b0;
        if (fade_cmd == CmdSnap) begin
            w_state_nxt = StIdle;
            w_level_nxt = LVL_MAX;
        end else begin
            case (r_state)
                StIdle: begin
                    if (fade_cmd == CmdOut) w_state_nxt = StFadeOut;
                end
                StDark: begin
                    if (fade_cmd == CmdIn) w_state_nxt = StFadeIn;
                end
                StFadeOut: begin
                    if (frame_start) begin
                        if (r_level <= LVL_STEP) begin
                            w_level_nxt = '0;
                            w_state_nxt = StDark;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_level_nxt = r_level - LVL_STEP;
                        end
                    end
                end
                StFadeIn: begin
                    if (frame_start) begin
                        if (r_level >= LVL_MAX - LVL_STEP) begin
                            w_level_nxt = LVL_MAX;
                            w_state_nxt = StIdle;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_level_nxt = r_level + LVL_STEP;
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= StIdle;
            r_level <= LVL_MAX;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign fade_busy = (r_state == StFadeOut) || (r_state == StFadeIn);
    assign fade_done = r_done;

    // Stage 2: gradient on blue, then brightness scaling
    logic            w_grad;
    logic [CH_W-1:0] w_r;
    logic [CH_W-1:0] w_g;
    logic [CH_W-1:0] w_b;
    logic [DW-1:0]   w_b_ext;
    logic [DW-1:0]   w_amt;
    logic [CH_W-1:0] w_b_grad;

    always_comb begin
        w_grad  = r_rd_data[3*CH_W];
        w_r     = r_rd_data[3*CH_W-1:2*CH_W];
        w_g     = r_rd_data[2*CH_W-1:CH_W];
        w_b     = r_rd_data[CH_W-1:0];
        w_b_ext = DW'(w_b);
        w_amt   = DW'(r_x1);
        w_b_grad = w_b;
        if (w_grad) begin
            w_b_grad = (w_amt >= w_b_ext) ? '0 : CH_W'(w_b_ext - w_amt);
        end
    end

    logic [CH_W-1:0] r_r;
    logic [CH_W-1:0] r_g;
    logic [CH_W-1:0] r_b;
    logic            r_v2;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_r <= scale(w_r, r_level);
                r_g <= scale(w_g, r_level);
                r_b <= scale(w_b_grad, r_level);
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
        end
    end

    assign R             = r_r;
    assign G             = r_g;
    assign B             = r_b;
    assign pix_valid_out = r_v2;

endmodule

// File: tb/tb_palette_lut.sv
// Directed self-checking bench for palette_lut: lookup, gradient, collisions, fade FSM, reset.
module tb_palette_lut;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        pix_valid_in;
    logic [5:0]  idx_in;
    logic [9:0]  DrawX;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [24:0] wr_data;
    logic        frame_start;
    logic [1:0]  fade_cmd;
    logic [7:0]  R, G, B;
    logic        pix_valid_out, fade_busy, fade_done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    palette_lut dut (
        .Clk(Clk), .Reset(Reset), .pix_valid_in(pix_valid_in), .idx_in(idx_in),
        .DrawX(DrawX), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start), .fade_cmd(fade_cmd), .R(R), .G(G), .B(B),
        .pix_valid_out(pix_valid_out), .fade_busy(fade_busy), .fade_done(fade_done)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (fade_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [24:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_pix(input logic [5:0] i, input logic [9:0] x,
                            output logic [23:0] rgb, output logic v);
        pix_valid_in = 1'b1; idx_in = i; DrawX = x;
        tick();
        pix_valid_in = 1'b0;
        tick();
        rgb = {R, G, B};
        v = pix_valid_out;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic cmd(input logic [1:0] c);
        fade_cmd = c;
        tick();
        fade_cmd = 2'b00;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        checks++;
        if ({R, G, B} !== 24'h0) begin
            errors++; $display("FAIL reset_rgb got %h want 000000", {R, G, B});
        end
        checks++;
        if ({pix_valid_out, fade_busy, fade_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {pix_valid_out, fade_busy, fade_done});
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [23:0] rgb; logic v;
        wr(6'd5, 25'h0_B0_40_00);
        read_pix(6'd5, 10'd0, rgb, v);
        checks++;
        if (rgb !== 24'hB04000) begin
            errors++; $display("FAIL basic_rgb got %h want b04000", rgb);
        end
        checks++;
        if (v !== 1'b1) begin
            errors++; $display("FAIL basic_valid got %b want 1", v);
        end
        pix_valid_in = 1'b0; idx_in = 6'd5;
        tick(); tick();
        checks++;
        if ({pix_valid_out, R, G, B} !== 25'h0) begin
            errors++; $display("FAIL blank got %b/%h want 0/000000", pix_valid_out, {R, G, B});
        end
    endtask

    task automatic test_gradient();
        logic [23:0] rgb; logic v;
        wr(6'd0, 25'h1_3F_00_7F);
        wr(6'd1, 25'h1_00_00_10);
        read_pix(6'd0, 10'd80, rgb, v);
        checks++;
        if (rgb !== 24'h3F0075) begin
            errors++; $display("FAIL grad_x80 got %h want 3f0075", rgb);
        end
        read_pix(6'd0, 10'd0, rgb, v);
        checks++;
        if (rgb !== 24'h3F007F) begin
            errors++; $display("FAIL grad_x0 got %h want 3f007f", rgb);
        end
        read_pix(6'd0, 10'd1023, rgb, v);
        checks++;
        if (rgb !== 24'h3F0000) begin
            errors++; $display("FAIL grad_x1023 got %h want 3f0000", rgb);
        end
        read_pix(6'd1, 10'd1023, rgb, v);
        checks++;
        if (rgb !== 24'h000000) begin
            errors++; $display("FAIL grad_sat got %h want 000000", rgb);
        end
    endtask

    task automatic test_collision();
        wr(6'd3, 25'h0_11_11_11);
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 25'h0_22_22_22;
        pix_valid_in = 1'b1; idx_in = 6'd3; DrawX = 10'd0;
        tick();
        wr_en = 1'b0;
        tick();
        pix_valid_in = 1'b0;
        checks++;
        if ({R, G, B} !== 24'h111111) begin
            errors++; $display("FAIL collide_old got %h want 111111", {R, G, B});
        end
        tick();
        checks++;
        if ({R, G, B} !== 24'h222222) begin
            errors++; $display("FAIL collide_new got %h want 222222", {R, G, B});
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  idxs [4] = '{6'd5, 6'd3, 6'd5, 6'd0};
        logic [23:0] exps [4] = '{24'hB04000, 24'h222222, 24'hB04000, 24'h3F007F};
        DrawX = 10'd0;
        for (int k = 0; k < 6; k++) begin
            pix_valid_in = (k < 4);
            idx_in = idxs[k % 4];
            tick();
            if (k >= 1 && k <= 4) begin
                checks++;
                if ({pix_valid_out, R, G, B} !== {1'b1, exps[k-1]}) begin
                    errors++;
                    $display("FAIL b2b_%0d got %b/%h want 1/%h", k - 1, pix_valid_out,
                             {R, G, B}, exps[k-1]);
                end
            end
        end
        pix_valid_in = 1'b0;
    endtask

    task automatic test_fade();
        logic [23:0] rgb; logic v; int d0;
        wr(6'd2, 25'h0_F0_F0_F0);
        d0 = done_cnt;
        cmd(2'b01);
        checks++;
        if (fade_busy !== 1'b1) begin
            errors++; $display("FAIL fade_out_busy got %b want 1", fade_busy);
        end
        frames(8);
        read_pix(6'd2, 10'd0, rgb, v);
        checks++;
        if (rgb !== 24'h787878) begin
            errors++; $display("FAIL fade_lvl8 got %h want 787878", rgb);
        end
        frames(7);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (fade_done !== 1'b1) begin
            errors++; $display("FAIL fade_out_done_pulse got %b want 1", fade_done);
        end
        tick();
        read_pix(6'd2, 10'd0, rgb, v);
        checks++;
        if ({fade_busy, rgb} !== 25'h0) begin
            errors++; $display("FAIL fade_dark got busy=%b rgb=%h want 0/000000", fade_busy, rgb);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++; $display("FAIL fade_out_done_count got %0d want 1", done_cnt - d0);
        end
        cmd(2'b10);
        checks++;
        if (fade_busy !== 1'b1) begin
            errors++; $display("FAIL fade_in_busy got %b want 1", fade_busy);
        end
        frames(16);
        read_pix(6'd2, 10'd0, rgb, v);
        checks++;
        if ({fade_busy, rgb} !== {1'b0, 24'hF0F0F0}) begin
            errors++; $display("FAIL fade_in_full got busy=%b rgb=%h want 0/f0f0f0", fade_busy, rgb);
        end
        checks++;
        if (done_cnt - d0 !== 2) begin
            errors++; $display("FAIL fade_in_done_count got %0d want 2", done_cnt - d0);
        end
    endtask

    task automatic test_snap();
        logic [23:0] rgb; logic v; int d0;
        d0 = done_cnt;
        cmd(2'b10);
        checks++;
        if (fade_busy !== 1'b0) begin
            errors++; $display("FAIL ignore_in_idle got busy=%b want 0", fade_busy);
        end
        // Command and frame_start together: no step on that frame
        fade_cmd = 2'b01; frame_start = 1'b1;
        tick();
        fade_cmd = 2'b00; frame_start = 1'b0;
        frames(9);
        read_pix(6'd2, 10'd0, rgb, v);
        checks++;
        if (rgb !== 24'h696969) begin
            errors++; $display("FAIL fade_lvl7 got %h want 696969", rgb);
        end
        cmd(2'b11);
        checks++;
        if (fade_busy !== 1'b0) begin
            errors++; $display("FAIL snap_busy got %b want 0", fade_busy);
        end
        read_pix(6'd2, 10'd0, rgb, v);
        checks++;
        if (rgb !== 24'hF0F0F0) begin
            errors++; $display("FAIL snap_full got %h want f0f0f0", rgb);
        end
        checks++;
        if (done_cnt !== d0) begin
            errors++; $display("FAIL snap_no_done got %0d pulses want 0", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_fade();
        logic [23:0] rgb; logic v;
        cmd(2'b01);
        frames(9);
        pix_valid_in = 1'b1; idx_in = 6'd2; DrawX = 10'd0;
        tick(); tick();
        checks++;
        if ({pix_valid_out, R, G, B} !== {1'b1, 24'h696969}) begin
            errors++;
            $display("FAIL pre_reset got %b/%h want 1/696969", pix_valid_out, {R, G, B});
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({pix_valid_out, R, G, B} !== 25'h0) begin
            errors++;
            $display("FAIL async_reset got %b/%h want 0/000000", pix_valid_out, {R, G, B});
        end
        pix_valid_in = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        checks++;
        if (fade_busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_busy got %b want 0", fade_busy);
        end
        read_pix(6'd2, 10'd0, rgb, v);
        checks++;
        if (rgb !== 24'hF0F0F0) begin
            errors++; $display("FAIL post_reset_lvl got %h want f0f0f0", rgb);
        end
        read_pix(6'd5, 10'd0, rgb, v);
        checks++;
        if (rgb !== 24'hB04000) begin
            errors++; $display("FAIL ram_retained got %h want b04000", rgb);
        end
    endtask

    initial begin
        Reset = 1'b1; pix_valid_in = 1'b0; idx_in = '0; DrawX = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; frame_start = 1'b0; fade_cmd = 2'b00;
        test_reset();
        test_basic();
        test_gradient();
        test_collision();
        test_back_to_back();
        test_fade();
        test_snap();
        test_reset_mid_fade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/palette_lut.md
Name: palette_lut

Overview:
- Programmable, pipelined colour-index to 24-bit RGB palette for the VGA pixel path, sitting between the sprite/background compositor and the VGA output registers.
- Replaces the fixed case-table palette with a writable lookup RAM.
- Any entry can be flagged to use the horizontal background gradient.
- Adds a frame-synchronous global fade (fade-out/fade-in) engine for screen transitions.

Parameters:
- IDX_W, 6, colour index width; palette holds 2**IDX_W entries.
- CH_W, 8, bits per colour channel; R, G and B are each CH_W wide.
- LVL_W, 4, fade level resolution; level ranges 0..2**LVL_W (MAX).
- FADE_STEP, 1, level change applied per frame_start while fading.
- GRAD_SHIFT, 3, gradient slope; gradient amount = DrawX >> GRAD_SHIFT.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-high reset.
- pix_valid_in  in  1  idx_in/DrawX are an active pixel this cycle.
- idx_in  in  IDX_W  colour index from compositor.
- DrawX  in  10  current pixel column, aligned with idx_in.
- wr_en  in  1  palette write strobe.
- wr_addr  in  IDX_W  entry to write.
- wr_data  in  3*CH_W+1  {grad_flag, R, G, B}.
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge).
- fade_cmd  in  2  00 none, 01 fade out, 10 fade in, 11 snap to full brightness.
- R, G, B  out  CH_W each  output colour.
- pix_valid_out  out  1  R/G/B correspond to an active pixel.
- fade_busy  out  1  high in FADING_OUT or FADING_IN.
- fade_done  out  1  one-cycle pulse when a fade completes.

Behaviour:
- Reset values: R=G=B=0, pix_valid_out=0, fade_busy=0, fade_done=0, level=MAX, state=IDLE, pipeline valids=0.
- Reset does not clear palette RAM. Contents are undefined at power-up and retained across Reset. Software programs every entry it uses.
- Palette RAM write: synchronous on wr_en.
- Palette RAM read: synchronous.
- Same-cycle read and write to the same address returns the OLD data. The new data is visible to reads one cycle later.
- Pipeline latency is 2 cycles:
  - Stage 1: RAM read; idx valid and DrawX delayed in parallel.
  - Stage 2: gradient, then scale; results registered.
- Throughput: one pixel per cycle, no stalls.
- Gradient (grad_flag=1 only):
  - B' = max(B - DrawX[9:GRAD_SHIFT], 0), saturating.
  - R and G pass through unchanged.
- Scaling: each channel out = (c * level) >> LVL_W, computed at CH_W+LVL_W+1 bits. level=MAX gives exactly c; level=0 gives 0.
- The level used is the value registered at the stage-2 input cycle.
- When stage-2 valid=0, R/G/B are forced to 0 (blanking).
- Fade FSM states: IDLE (level=MAX), FADING_OUT, DARK (level=0), FADING_IN.
  - IDLE + cmd 01 -> FADING_OUT.
  - DARK + cmd 10 -> FADING_IN.
  - FADING_OUT: each frame_start subtracts FADE_STEP from level, saturating at 0. On reaching 0 -> DARK, with fade_done pulsed the same cycle level becomes 0.
  - FADING_IN: each frame_start adds FADE_STEP, saturating at MAX. On reaching MAX -> IDLE, with fade_done pulsed.
  - cmd 11 from any state: level=MAX and state=IDLE next cycle; no fade_done pulse.
  - cmd 01 outside IDLE is ignored. cmd 10 outside DARK is ignored.
  - A command and frame_start in the same cycle: the command is taken; the first step occurs at the next frame_start.
- Reset mid-fade: immediately returns to the reset values above.

Test Plan:
- Basic lookup: write addr 5 = {0,0xB0,0x40,0x00}; drive idx 5 with valid -> exactly 2 cycles later R=0xB0, G=0x40, B=0x00, pix_valid_out=1. With valid low, RGB=0.
- Gradient: addr 0 = {1,0x3F,0x00,0x7F}. DrawX=80 -> B=0x75, R=0x3F. DrawX=1023 -> B=0x00. Addr 1 = {1,0,0,0x10} at DrawX=1023 -> B=0x00 (saturated, no wrap).
- Read/write collision: addr 3 holds 0x111111. Write 0x222222 to addr 3 while reading idx 3 -> output 0x111111. Next-cycle read -> 0x222222.
- Fade: addr 2 = 0xF0F0F0; cmd 01 in IDLE; 8 frame_starts -> level 8, output 0x787878. After 16 frame_starts -> level 0, fade_done pulses once, RGB=0, state DARK. cmd 10 plus 16 frame_starts -> back to 0xF0F0F0, one fade_done.
- Ignored and snap commands: cmd 10 in IDLE -> no state change. Mid fade-out at level 7, cmd 11 -> level 16 next cycle, fade_busy=0, no fade_done.
- Reset mid-fade: at level 7, assert Reset asynchronously (no clock edge) -> RGB=0 and pix_valid_out=0 immediately. After release, level 16 and IDLE, and palette entries still read back their programmed values.
